// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op encoding and controller states.
// Pure declarations: no logic, no latency, no flow control.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_NOT = 4'd6,
    OP_SLL = 4'd7,
    OP_SRL = 4'd8,
    OP_SRA = 4'd9,
    OP_XOR = 4'd10,
    OP_SLT = 4'd11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the control unit (master) and the ALU (slave).
// The master holds off on busy and captures the result on the done pulse.
interface alu_seq_if #(
  parameter int N = 32
);

  logic         start;
  logic [3:0]   S;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] Z;
  logic [N-1:0] Zhi;
  logic         zero;
  logic         ovf;
  logic         dz;
  logic         illegal;

  modport master (
    output start, S, A, B,
    input  busy, done, Z, Zhi, zero, ovf, dz, illegal
  );

  modport slave (
    input  start, S, A, B,
    output busy, done, Z, Zhi, zero, ovf, dz, illegal
  );

endinterface

// File: rtl/alu_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per clock, N steps after go.
// No flow control: go reloads the engine; lo/hi show the result of the step taken this cycle, fin marks the last step.
module alu_muldiv #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         go,
  input  logic         is_div,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] lo,
  output logic [N-1:0] hi,
  output logic         fin
);

  localparam int CW = $clog2(N + 1);

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   opnd_q, opnd_d;
  logic           div_q, div_d;

  logic [2*N-1:0] step;
  logic [N-1:0]   addend;
  logic [N:0]     mul_sum;
  logic [N:0]     div_tmp;
  logic [N-1:0]   div_sub;
  logic           div_ge;

  always_comb begin
    // acc = {partial product, multiplier} for MUL, {remainder, dividend/quotient} for DIV
    addend  = acc_q[0] ? opnd_q : '0;
    mul_sum = {1'b0, acc_q[2*N-1:N]} + {1'b0, addend};
    div_tmp = acc_q[2*N-1:N-1];
    div_ge  = (div_tmp >= {1'b0, opnd_q});
    div_sub = div_tmp[N-1:0] - opnd_q;
    if (div_q) begin
      step = {(div_ge ? div_sub : div_tmp[N-1:0]), acc_q[N-2:0], div_ge};
    end else begin
      step = {mul_sum, acc_q[N-1:1]};
    end

    cnt_d  = cnt_q;
    acc_d  = acc_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    if (go) begin
      cnt_d  = CW'(N);
      acc_d  = {{N{1'b0}}, (is_div ? a : b)};
      opnd_d = is_div ? b : a;
      div_d  = is_div;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      acc_d = step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
    end
  end

  assign lo  = step[N-1:0];
  assign hi  = step[2*N-1:N];
  assign fin = (cnt_q == CW'(1));

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops finish one cycle after start, MUL/DIV N+1 cycles after start.
// start is taken only in IDLE; a start while busy or done is dropped, never queued.
module alu_seq
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);

  localparam int SHW = $clog2(N);

  state_t       state_q, state_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [N-1:0] z_q, z_d;
  logic [N-1:0] zhi_q, zhi_d;
  logic         zero_q, zero_d;
  logic         ovf_q, ovf_d;
  logic         dz_q, dz_d;
  logic         ill_q, ill_d;

  op_t          op;
  logic [SHW-1:0] shamt;
  logic [N-1:0] sum, diff;
  logic [N-1:0] r_z, r_zhi;
  logic         r_ovf, r_dz, r_ill;
  logic         go, is_div;
  logic [N-1:0] md_lo, md_hi;
  logic         md_fin;

  alu_muldiv #(.N(N)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .go     (go),
    .is_div (is_div),
    .a      (bus.A),
    .b      (bus.B),
    .lo     (md_lo),
    .hi     (md_hi),
    .fin    (md_fin)
  );

  always_comb begin
    op    = op_t'(bus.S);
    shamt = bus.B[SHW-1:0];
    sum   = bus.A + bus.B;
    diff  = bus.A - bus.B;
    r_z   = '0;
    r_zhi = '0;
    r_ovf = 1'b0;
    r_dz  = 1'b0;
    r_ill = 1'b0;
    case (op)
      OP_ADD: begin
        r_z   = sum;
        r_ovf = (bus.A[N-1] == bus.B[N-1]) && (sum[N-1] != bus.A[N-1]);
      end
      OP_SUB: begin
        r_z   = diff;
        r_ovf = (bus.A[N-1] != bus.B[N-1]) && (diff[N-1] != bus.A[N-1]);
      end
      OP_MUL: ;
      // only reaches DONE directly when B==0; a real divide goes through the engine
      OP_DIV: begin
        r_z   = '1;
        r_zhi = bus.A;
        r_dz  = 1'b1;
      end
      OP_AND: r_z = bus.A & bus.B;
      OP_OR:  r_z = bus.A | bus.B;
      OP_NOT: r_z = ~bus.A;
      OP_SLL: r_z = bus.A << shamt;
      OP_SRL: r_z = bus.A >> shamt;
      OP_SRA: r_z = $signed(bus.A) >>> shamt;
      OP_XOR: r_z = bus.A ^ bus.B;
      OP_SLT: r_z = {{(N-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      default: r_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    z_d     = z_q;
    zhi_d   = zhi_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    ill_d   = ill_q;
    is_div  = (op == OP_DIV);
    go      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (op == OP_MUL || (op == OP_DIV && bus.B != '0)) begin
            state_d = (op == OP_MUL) ? MUL : DIV;
            busy_d  = 1'b1;
            go      = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            z_d     = r_z;
            zhi_d   = r_zhi;
            zero_d  = (r_z == '0);
            ovf_d   = r_ovf;
            dz_d    = r_dz;
            ill_d   = r_ill;
          end
        end
      end
      MUL, DIV: begin
        busy_d = 1'b1;
        if (md_fin) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          z_d     = md_lo;
          zhi_d   = md_hi;
          zero_d  = (md_lo == '0);
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
          ill_d   = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      z_q     <= '0;
      zhi_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      z_q     <= z_d;
      zhi_q   <= zhi_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.Z       = z_q;
  assign bus.Zhi     = zhi_q;
  assign bus.zero    = zero_q;
  assign bus.ovf     = ovf_q;
  assign bus.dz      = dz_q;
  assign bus.illegal = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed corner cases then random ops, checked against an arithmetic model.
// Latency, busy length, result fields and hold behaviour are compared for every operation.
module tb_alu_seq;

  typedef struct packed {
    logic [31:0] z;
    logic [31:0] zhi;
    logic        zero;
    logic        ovf;
    logic        dz;
    logic        ill;
    logic [7:0]  lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  alu_seq_if #(.N(32)) bus ();

  alu_seq #(.N(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb, r;
    longint      smax, smin;
    logic [63:0] p;
    int          sh;
    e    = '0;
    e.lat = 8'd1;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    smax = 64'sd2147483647;
    smin = -smax - 1;
    sh   = int'(b % 32);
    case (s)
      4'd0: begin r = sa + sb; e.z = a + b; e.ovf = (r > smax) || (r < smin); end
      4'd1: begin r = sa - sb; e.z = a - b; e.ovf = (r > smax) || (r < smin); end
      4'd2: begin
        p = 64'(a) * 64'(b);
        e.z = p[31:0]; e.zhi = p[63:32]; e.lat = 8'd33;
      end
      4'd3: begin
        if (b == 0) begin e.z = '1; e.zhi = a; e.dz = 1'b1; end
        else begin e.z = a / b; e.zhi = a % b; e.lat = 8'd33; end
      end
      4'd4:  e.z = a & b;
      4'd5:  e.z = a | b;
      4'd6:  e.z = ~a;
      4'd7:  e.z = a << sh;
      4'd8:  e.z = a >> sh;
      4'd9:  e.z = 32'(sa >>> sh);
      4'd10: e.z = a ^ b;
      4'd11: e.z = (sa < sb) ? 32'd1 : 32'd0;
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.z == 0);
    return e;
  endfunction

  // poke: cycle at which a stray ADD start is pulsed while the op is in flight (0 = never)
  task automatic run(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b, input int poke);
    exp_t e;
    int   cyc, nbusy, extra;
    e = model(s, a, b);
    @(negedge clk);
    bus.start = 1'b1; bus.S = s; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom;
    cyc = 1; nbusy = 0;
    while (!bus.done && cyc < 60) begin
      if (bus.busy) nbusy++;
      if (cyc == poke) begin bus.start = 1'b1; bus.S = 4'd0; end
      else bus.start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    chk($sformatf("lat op%0d", s), 64'(cyc), 64'(e.lat));
    chk($sformatf("busy op%0d", s), 64'(nbusy), 64'(e.lat) - 64'd1);
    chk($sformatf("Z op%0d", s), 64'(bus.Z), 64'(e.z));
    chk($sformatf("Zhi op%0d", s), 64'(bus.Zhi), 64'(e.zhi));
    chk($sformatf("flags op%0d", s), 64'({bus.zero, bus.ovf, bus.dz, bus.illegal}),
        64'({e.zero, e.ovf, e.dz, e.ill}));
    extra = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (bus.done) extra++;
    end
    chk($sformatf("single done op%0d", s), 64'(extra), 64'd0);
    chk($sformatf("hold Z op%0d", s), 64'(bus.Z), 64'(e.z));
  endtask

  initial begin
    int extra;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.S = 4'd0; bus.A = '0; bus.B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy/done", 64'({bus.busy, bus.done}), 64'd0);
    chk("reset Z", 64'(bus.Z), 64'd0);
    chk("reset Zhi", 64'(bus.Zhi), 64'd0);
    chk("reset flags", 64'({bus.zero, bus.ovf, bus.dz, bus.illegal}), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    run(4'd0, 32'd7, 32'd5, 0);
    chk("ADD 7+5", 64'(bus.Z), 64'd12);
    run(4'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("SUB ovf", 64'({bus.Z, bus.ovf}), {31'd0, 32'h8000_0000, 1'b1});
    run(4'd11, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0);
    run(4'd2, 32'hFFFF_FFFF, 32'd2, 5);
    chk("MUL hi/lo", 64'({bus.Zhi, bus.Z}), 64'h0000_0001_FFFF_FFFE);
    run(4'd3, 32'd100, 32'd7, 0);
    chk("DIV 100/7", 64'({bus.Zhi, bus.Z}), {32'd2, 32'd14});
    run(4'd3, 32'd9, 32'd0, 0);
    chk("DIV by 0 dz", 64'(bus.dz), 64'd1);
    run(4'b1110, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    chk("illegal", 64'({bus.illegal, bus.Z}), {31'd0, 1'b1, 32'd0});
    run(4'd9, 32'h8000_0000, 32'd31, 0);
    chk("SRA 31", 64'(bus.Z), 64'hFFFF_FFFF);
    run(4'd7, 32'h0000_0003, 32'd33, 0);
    chk("SLL wrap", 64'(bus.Z), 64'd6);
    run(4'd8, 32'hDEAD_BEEF, 32'd0, 0);
    run(4'd0, 32'hFFFF_FFFF, 32'd1, 0);

    run(4'd7, 32'h0000_0003, 32'd33, 0);
    @(negedge clk);
    bus.start = 1'b1; bus.S = 4'd3; bus.A = 32'd1000; bus.B = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort busy/done", 64'({bus.busy, bus.done}), 64'd0);
    chk("abort Z/Zhi", 64'({bus.Zhi, bus.Z}), 64'd0);
    chk("abort flags", 64'({bus.zero, bus.ovf, bus.dz, bus.illegal}), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    extra = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) extra++;
    end
    chk("no done after abort", 64'(extra), 64'd0);
    run(4'd0, 32'd20, 32'd22, 0);

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  s;
      logic [31:0] a, b;
      s = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      run(s, a, b, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
